// File: rtl/m_cycleacc_pkg.sv
// Shared encodings for the mcycle/minstret accumulator.
package m_cycleacc_pkg;

    typedef enum logic [1:0] {
        SEL_CYC_LO = 2'b00,
        SEL_CYC_HI = 2'b01,
        SEL_INS_LO = 2'b10,
        SEL_INS_HI = 2'b11
    } sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } acc_state_e;

    // A ccnt of 0 is the bus-error overflow case and stands for a full 64 cycles.
    localparam int unsigned CCNT_ZERO_MEANS = 64;

    function automatic logic [31:0] ccnt_to_inc(input logic [5:0] ccnt);
        if (ccnt == 6'd0) return 32'(CCNT_ZERO_MEANS);
        return {26'b0, ccnt};
    endfunction

endpackage

// File: rtl/m_cycleacc_if.sv
// CSR access bus: strobes held by the master until rd_ack.
interface m_cycleacc_if;
    logic        rd_stb;
    logic        wr_stb;
    logic [1:0]  sel;
    logic [31:0] wr_dat;
    logic [31:0] rd_dat;
    logic        rd_ack;

    modport master (output rd_stb, wr_stb, sel, wr_dat, input rd_dat, rd_ack);
    modport slave  (input rd_stb, wr_stb, sel, wr_dat, output rd_dat, rd_ack);
endinterface

// File: rtl/m_cycleacc_half64.sv
// One 64-bit counter built as a 32-bit low add plus a registered carry into
// the high half, with a high-half shadow for coherent lo-then-hi reads.
module m_cycleacc_half64 #(
    parameter bit HIGHLEVEL = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inc_en_i,
    input  logic [31:0] inc_val_i,
    input  logic        wr_lo_i,
    input  logic        wr_hi_i,
    input  logic [31:0] wr_dat_i,
    input  logic        snap_i,
    input  logic        shd_clr_i,
    output logic [31:0] lo_o,
    output logic [31:0] hi_o,
    output logic [31:0] shd_o,
    output logic        cp_o,
    output logic        shd_vld_o
);

    logic [31:0] lo_q, lo_d, hi_q, hi_d, shd_q, shd_d;
    logic        cp_q, cp_d, vld_q, vld_d;
    logic [32:0] sum;

    if (HIGHLEVEL) begin : g_beh
        assign sum = {1'b0, lo_q} + {1'b0, inc_val_i};
    end else begin : g_prim
        // Explicit ripple adder standing in for the primitive-level netlist.
        logic [32:0] carry;
        assign carry[0] = 1'b0;
        for (genvar i = 0; i < 32; i++) begin : g_fa
            assign sum[i]     = lo_q[i] ^ inc_val_i[i] ^ carry[i];
            assign carry[i+1] = (lo_q[i] & inc_val_i[i]) | (carry[i] & (lo_q[i] ^ inc_val_i[i]));
        end
        assign sum[32] = carry[32];
    end

    // Next-state: a written lo wins over an increment and produces no carry;
    // the high half consumes last cycle's carry every cycle unless written.
    always_comb begin
        lo_d = lo_q;
        if (wr_lo_i) begin
            lo_d = wr_dat_i;
        end else if (inc_en_i) begin
            lo_d = sum[31:0];
        end
        cp_d  = inc_en_i & ~wr_lo_i & sum[32];
        hi_d  = wr_hi_i ? wr_dat_i : hi_q + {31'b0, cp_q};
        shd_d = snap_i ? hi_q : shd_q;
        vld_d = vld_q;
        if (wr_lo_i || wr_hi_i) begin
            vld_d = 1'b0;
        end else if (snap_i) begin
            vld_d = 1'b1;
        end else if (shd_clr_i) begin
            vld_d = 1'b0;
        end
    end

    // Counter, carry and shadow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lo_q  <= '0;
            hi_q  <= '0;
            shd_q <= '0;
            cp_q  <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            lo_q  <= lo_d;
            hi_q  <= hi_d;
            shd_q <= shd_d;
            cp_q  <= cp_d;
            vld_q <= vld_d;
        end
    end

    assign lo_o      = lo_q;
    assign hi_o      = hi_q;
    assign shd_o     = shd_q;
    assign cp_o      = cp_q;
    assign shd_vld_o = vld_q;

endmodule

// File: rtl/m_cycleacc.sv
// mcycle/minstret accumulator fed by the instruction timer, with a 32-bit
// CSR port. Accesses to a counter wait one cycle while its carry is pending.
//   state | meaning
//   IDLE  | waiting for a strobe with no carry pending on the selected counter
//   ACK   | rd_ack high, rd_dat driven, write performed
module m_cycleacc
    import m_cycleacc_pkg::*;
#(
    parameter int HIGHLEVEL  = 1,
    parameter int NO_INSTRET = 0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         corerunning,
    input  logic         retire,
    input  logic [5:0]   ccnt,
    m_cycleacc_if.slave  bus
);

    acc_state_e  state_q, state_d;
    logic [31:0] rd_dat_q, rd_dat_d, rd_mux;
    logic        ret_en, go, ack, sel_cp, rd_only;
    logic [31:0] cyc_lo, cyc_hi, cyc_shd, ins_lo, ins_hi, ins_shd;
    logic        cyc_cp, cyc_vld, ins_cp, ins_vld;

    assign ret_en  = retire & corerunning;
    assign ack     = (state_q == ST_ACK);
    assign go      = (state_q == ST_IDLE) && (state_d == ST_ACK);
    assign rd_only = bus.rd_stb & ~bus.wr_stb;

    m_cycleacc_half64 #(.HIGHLEVEL(HIGHLEVEL != 0)) u_cyc (
        .clk       (clk),
        .rst_n     (rst_n),
        .inc_en_i  (ret_en),
        .inc_val_i (ccnt_to_inc(ccnt)),
        .wr_lo_i   (ack && bus.wr_stb && (bus.sel == SEL_CYC_LO)),
        .wr_hi_i   (ack && bus.wr_stb && (bus.sel == SEL_CYC_HI)),
        .wr_dat_i  (bus.wr_dat),
        .snap_i    (go && rd_only && (bus.sel == SEL_CYC_LO)),
        .shd_clr_i (go && rd_only && (bus.sel == SEL_CYC_HI)),
        .lo_o      (cyc_lo),
        .hi_o      (cyc_hi),
        .shd_o     (cyc_shd),
        .cp_o      (cyc_cp),
        .shd_vld_o (cyc_vld)
    );

    if (NO_INSTRET == 0) begin : g_ins
        m_cycleacc_half64 #(.HIGHLEVEL(HIGHLEVEL != 0)) u_ins (
            .clk       (clk),
            .rst_n     (rst_n),
            .inc_en_i  (ret_en),
            .inc_val_i (32'd1),
            .wr_lo_i   (ack && bus.wr_stb && (bus.sel == SEL_INS_LO)),
            .wr_hi_i   (ack && bus.wr_stb && (bus.sel == SEL_INS_HI)),
            .wr_dat_i  (bus.wr_dat),
            .snap_i    (go && rd_only && (bus.sel == SEL_INS_LO)),
            .shd_clr_i (go && rd_only && (bus.sel == SEL_INS_HI)),
            .lo_o      (ins_lo),
            .hi_o      (ins_hi),
            .shd_o     (ins_shd),
            .cp_o      (ins_cp),
            .shd_vld_o (ins_vld)
        );
    end else begin : g_no_ins
        assign ins_lo  = '0;
        assign ins_hi  = '0;
        assign ins_shd = '0;
        assign ins_cp  = 1'b0;
        assign ins_vld = 1'b0;
    end

    // Carry flag of the selected counter and the value a read would return;
    // hi reads prefer the shadow taken by the preceding lo read.
    always_comb begin
        sel_cp = 1'b0;
        rd_mux = '0;
        case (sel_e'(bus.sel))
            SEL_CYC_LO: begin sel_cp = cyc_cp; rd_mux = cyc_lo; end
            SEL_CYC_HI: begin sel_cp = cyc_cp; rd_mux = cyc_vld ? cyc_shd : cyc_hi; end
            SEL_INS_LO: begin sel_cp = ins_cp; rd_mux = ins_lo; end
            SEL_INS_HI: begin sel_cp = ins_cp; rd_mux = ins_vld ? ins_shd : ins_hi; end
            default:    begin sel_cp = 1'b0;   rd_mux = '0; end
        endcase
    end

    // Access FSM next state; data is captured on entry to ACK so it is pre-write.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if ((bus.rd_stb || bus.wr_stb) && !sel_cp) state_d = ST_ACK;
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        rd_dat_d = go ? rd_mux : '0;
    end

    // FSM state and registered read data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            rd_dat_q <= '0;
        end else begin
            state_q  <= state_d;
            rd_dat_q <= rd_dat_d;
        end
    end

    assign bus.rd_ack = ack;
    assign bus.rd_dat = rd_dat_q;

endmodule
